// File: rtl/odata_pool_axi4_split.sv
// AXI4 read engine: splits requests into 4 KB-safe bursts, bounds outstanding bursts, and
// returns data through a credit-reserved pool as one stream packet per request.
module odata_pool_axi4_split #(
    parameter int unsigned DSIZE           = 64,
    parameter int unsigned ASIZE           = 32,
    parameter int unsigned LSIZE           = 8,
    parameter int unsigned IDSIZE          = 4,
    parameter int unsigned EXSIZE          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned POOL_DEPTH      = 512,
    parameter int unsigned EX_DEPTH        = 8
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ASIZE-1:0]  req_addr,
    input  logic [31:0]       req_len,
    input  logic [EXSIZE-1:0] req_ex,
    output logic [IDSIZE-1:0] axi_arid,
    output logic [ASIZE-1:0]  axi_araddr,
    output logic [LSIZE-1:0]  axi_arlen,
    output logic [2:0]        axi_arsize,
    output logic [1:0]        axi_arburst,
    output logic              axi_arlock,
    output logic [3:0]        axi_arcache,
    output logic [2:0]        axi_arprot,
    output logic [3:0]        axi_arqos,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [DSIZE-1:0]  axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    output logic [DSIZE-1:0]  out_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic              out_tlast,
    output logic [EXSIZE-1:0] out_ex,
    output logic              out_err,
    output logic              busy
);
    localparam int unsigned BYTES  = DSIZE / 8;
    localparam int unsigned BSHIFT = $clog2(BYTES);
    localparam int unsigned MAXB   = 2 ** LSIZE;
    localparam int unsigned BW     = LSIZE + 1;
    localparam int unsigned CW     = $clog2(POOL_DEPTH + 1);
    localparam int unsigned PAW    = (POOL_DEPTH > 1) ? $clog2(POOL_DEPTH) : 1;
    localparam int unsigned OW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TAW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned EW     = $clog2(EX_DEPTH + 1);
    localparam int unsigned EAW    = (EX_DEPTH > 1) ? $clog2(EX_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StIssue} state_e;

    state_e             state_q, state_d;
    logic [ASIZE-1:0]   addr_q, addr_d;
    logic [31:0]        rem_q, rem_d;
    logic [BW-1:0]      blen_q, blen_d;
    logic               last_q, last_d;
    logic [OW-1:0]      ost_q, ost_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic               err_q, err_d;
    logic [TAW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [OW-1:0]      tag_cnt_q, tag_cnt_d;
    logic [EAW-1:0]     info_wr_q, info_wr_d, info_rd_q, info_rd_d;
    logic [EW-1:0]      info_cnt_q, info_cnt_d;
    logic [PAW-1:0]     pool_wr_q, pool_wr_d, pool_rd_q, pool_rd_d;
    logic [CW-1:0]      pool_cnt_q, pool_cnt_d;

    logic               tag_mem  [MAX_OUTSTANDING];
    logic [EXSIZE-1:0]  info_mem [EX_DEPTH];
    logic [DSIZE+1:0]   pool_mem [POOL_DEPTH];

    logic [12:0]        b4k;
    logic [32:0]        blen_c;
    logic               info_push, info_pop, ar_hs, r_hs, out_hs;
    logic               tag_empty, tag_pop, wr_last, wr_err, err_now;
    logic [DSIZE+1:0]   pool_head;

    // Splitter FSM: IDLE accepts, CALC sizes the next burst, ISSUE drives AR.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        blen_d      = blen_q;
        last_d      = last_q;
        req_ready   = 1'b0;
        axi_arvalid = 1'b0;
        info_push   = 1'b0;
        b4k         = (13'd4096 - {1'b0, addr_q[11:0]}) >> BSHIFT;
        blen_c      = {1'b0, rem_q};
        if (blen_c > 33'(MAXB)) blen_c = 33'(MAXB);
        if (blen_c > 33'(b4k))  blen_c = 33'(b4k);
        unique case (state_q)
            StIdle: begin
                req_ready = (info_cnt_q != EW'(EX_DEPTH));
                if (req_valid && req_ready && req_len != 32'd0) begin
                    addr_d    = req_addr;
                    rem_d     = req_len;
                    info_push = 1'b1;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                blen_d  = BW'(blen_c);
                last_d  = (blen_c == {1'b0, rem_q});
                state_d = StIssue;
            end
            StIssue: begin
                // Both conditions can only improve until arready, so arvalid holds once raised.
                axi_arvalid = (ost_q < OW'(MAX_OUTSTANDING)) && (credit_q >= CW'(blen_q));
                if (axi_arvalid && axi_arready) begin
                    addr_d  = addr_q + (ASIZE'(blen_q) << BSHIFT);
                    rem_d   = rem_q - 32'(blen_q);
                    state_d = (rem_d != 32'd0) ? StCalc : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ar_hs     = axi_arvalid & axi_arready;
    assign r_hs      = axi_rvalid & axi_rready;
    assign out_hs    = out_tvalid & out_tready;
    assign tag_empty = (tag_cnt_q == '0);
    assign tag_pop   = r_hs & axi_rlast & ~tag_empty;
    assign wr_last   = axi_rlast & ~tag_empty & tag_mem[tag_rd_q];
    assign err_now   = (axi_rresp != 2'b00);
    assign wr_err    = wr_last & (err_q | err_now);
    assign pool_head = pool_mem[pool_rd_q];
    assign info_pop  = out_hs & out_tlast & (info_cnt_q != '0);

    always_comb begin
        ost_d      = ost_q;
        credit_d   = credit_q;
        err_d      = err_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        tag_cnt_d  = tag_cnt_q;
        info_wr_d  = info_wr_q;
        info_rd_d  = info_rd_q;
        info_cnt_d = info_cnt_q;
        pool_wr_d  = pool_wr_q;
        pool_rd_d  = pool_rd_q;
        pool_cnt_d = pool_cnt_q;
        if (ar_hs && !(r_hs && axi_rlast && ost_q != '0)) ost_d = ost_q + 1'b1;
        if (!ar_hs && r_hs && axi_rlast && ost_q != '0)   ost_d = ost_q - 1'b1;
        credit_d = credit_q - (ar_hs ? CW'(blen_q) : CW'(0)) + (out_hs ? CW'(1) : CW'(0));
        if (r_hs) begin
            if (wr_last)      err_d = 1'b0;
            else if (err_now) err_d = 1'b1;
        end
        if (ar_hs) tag_wr_d = (tag_wr_q == TAW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + 1'b1;
        if (tag_pop) tag_rd_d = (tag_rd_q == TAW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + 1'b1;
        tag_cnt_d = tag_cnt_q + OW'(ar_hs) - OW'(tag_pop);
        if (info_push) info_wr_d = (info_wr_q == EAW'(EX_DEPTH - 1)) ? '0 : info_wr_q + 1'b1;
        if (info_pop)  info_rd_d = (info_rd_q == EAW'(EX_DEPTH - 1)) ? '0 : info_rd_q + 1'b1;
        info_cnt_d = info_cnt_q + EW'(info_push) - EW'(info_pop);
        if (r_hs)   pool_wr_d = (pool_wr_q == PAW'(POOL_DEPTH - 1)) ? '0 : pool_wr_q + 1'b1;
        if (out_hs) pool_rd_d = (pool_rd_q == PAW'(POOL_DEPTH - 1)) ? '0 : pool_rd_q + 1'b1;
        pool_cnt_d = pool_cnt_q + CW'(r_hs) - CW'(out_hs);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rem_q      <= '0;
            blen_q     <= '0;
            last_q     <= 1'b0;
            ost_q      <= '0;
            credit_q   <= CW'(POOL_DEPTH);
            err_q      <= 1'b0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            tag_cnt_q  <= '0;
            info_wr_q  <= '0;
            info_rd_q  <= '0;
            info_cnt_q <= '0;
            pool_wr_q  <= '0;
            pool_rd_q  <= '0;
            pool_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            blen_q     <= blen_d;
            last_q     <= last_d;
            ost_q      <= ost_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_cnt_q  <= tag_cnt_d;
            info_wr_q  <= info_wr_d;
            info_rd_q  <= info_rd_d;
            info_cnt_q <= info_cnt_d;
            pool_wr_q  <= pool_wr_d;
            pool_rd_q  <= pool_rd_d;
            pool_cnt_q <= pool_cnt_d;
        end
    end

    // Storage arrays carry no reset; the pointers/counters define their validity.
    always_ff @(posedge axi_aclk) begin
        if (ar_hs)     tag_mem[tag_wr_q]   <= last_q;
        if (info_push) info_mem[info_wr_q] <= req_ex;
        if (r_hs)      pool_mem[pool_wr_q] <= {wr_err, wr_last, axi_rdata};
    end

    assign axi_arid    = '0;
    assign axi_araddr  = (state_q == StIssue) ? addr_q : '0;
    assign axi_arlen   = (state_q == StIssue) ? LSIZE'(blen_q - 1'b1) : '0;
    assign axi_arsize  = 3'(BSHIFT);
    assign axi_arburst = 2'b01;
    assign axi_arlock  = 1'b0;
    assign axi_arcache = 4'd0;
    assign axi_arprot  = 3'd0;
    assign axi_arqos   = 4'd0;
    assign axi_rready  = (pool_cnt_q != CW'(POOL_DEPTH));

    assign out_tvalid = (pool_cnt_q != '0);
    assign out_tdata  = out_tvalid ? pool_head[DSIZE-1:0] : '0;
    assign out_tlast  = out_tvalid & pool_head[DSIZE];
    assign out_err    = out_tlast & pool_head[DSIZE+1];
    assign out_ex     = out_tvalid ? info_mem[info_rd_q] : '0;

    assign busy = (state_q != StIdle) || (ost_q != '0) || (pool_cnt_q != '0) ||
                  (info_cnt_q != '0);
endmodule
